pad_encoder16: RTL and testbench
================================

Name: pad_encoder16

Overview:
- 16-pad keypad front end for the launchpad, and the inverse of the existing 4-to-16 pad decoder.
- Takes raw pad levels, then synchronises, debounces and edge-detects them.
- Each press becomes a 4-bit pad code (pad pN → code N-1), queued in a small FIFO.
- Codes are delivered to the sequencer/sound logic over a valid/ready handshake.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronised samples required before a pad's debounced state flips (legal range 1..255).
- FIFO_DEPTH, 4, code FIFO entries (power of 2, 2..16).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- pad_in  input  16  raw pad levels, active-high; bit i is pad p(i+1); asynchronous to clk.
- code_out  output  4  encoded pad index of the FIFO head (0..15).
- code_valid  output  1  FIFO non-empty; code_out is meaningful.
- code_ready  input  1  consumer accepts the head when code_valid && code_ready at a clk edge.
- overflow  output  1  one-cycle pulse: a press event was lost.
- pressed_any  output  1  OR of all debounced pad states.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset:
  - Synchronisers, debounced states, counters, pending mask and FIFO pointers all clear.
  - code_out=0, code_valid=0, overflow=0, pressed_any=0.
  - Reset mid-operation discards all pending and queued events immediately; nothing is emitted after release until new presses.
- Synchronisation: 2-FF synchroniser per bit.
- Debounce (per pad):
  - The counter increments on each edge where the synchronised value differs from the debounced state, and clears when they are equal.
  - When the counter reaches DEB_CYCLES, the debounced state takes the synchronised value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles produces no change.
- Press event:
  - A debounced 0→1 transition sets bit i of the 16-bit pending mask at the same edge.
  - If bit i is already pending, the new event is dropped and overflow pulses.
- Encoder/arbiter:
  - Each cycle, if the FIFO is not full and the pending mask is non-zero, the lowest-index pending bit is encoded, pushed and cleared.
  - At most 1 push per cycle.
  - FIFO full: the pending mask holds (no loss); pushing resumes on the first non-full cycle.
- Simultaneous events:
  - Several pads pressed on the same edge enter the FIFO lowest index first, one per cycle.
  - A push and a pop in the same cycle are both performed even when the FIFO is full.
- FIFO:
  - First-word fall-through; code_out is stable while code_valid && !code_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Pad held high from cycle 0 with an empty FIFO and pending mask: code_valid rises exactly DEB_CYCLES+4 edges later.
  - Breakdown: 2 sync, DEB_CYCLES debounce, 1 pending, 1 FIFO write.
- Releases: without the option below, releases only update pressed_any.
- pressed_any is registered from the debounced states (no extra delay beyond debounce).

Optional Feature:
- Macro: PAD_RELEASE_EVENT_EN.
- Defined:
  - A second 16-bit pending-release mask and a 1-bit code_release output are added; FIFO entries become 5 bits.
  - Debounced 1→0 transitions also queue events with code_release=1.
  - Arbitration each cycle: press mask before release mask, each lowest-index first.
  - A duplicate release while already pending pulses overflow.
- Undefined: no release logic and no code_release port; behaviour is exactly as above.

Decomposition:
- Package pad_enc_pkg:
  - NUM_PADS=16, CODE_W=4.
  - typedef pad_code_t (4-bit); typedef pad_mask_t (16-bit).
  - Function lowest_set_index(pad_mask_t) returning pad_code_t.
- Sub-module pad_debounce: one pad's synchroniser, counter and debounced state; instantiated 16 times.
- Arbiter and FIFO stay in the top level.

Test Plan:
- Reset, then pad_in=16'h0001 held with DEB_CYCLES=4, code_ready=1 → code_valid high for 1 cycle exactly 8 edges later; code_out=0; pressed_any=1.
- pad_in bit 5 pulsed high for 3 cycles (DEB_CYCLES=4) → no code_valid, pressed_any stays 0.
- pad_in=16'h8421 set in one cycle, code_ready=1 → codes 0,5,10,15 on consecutive cycles.
- code_ready=0, six distinct pads pressed → FIFO holds 4 (codes 0..3), 2 pending; overflow stays 0. Raising code_ready yields all 6 in index order.
- code_ready=0, FIFO full, pad 7 pending, then pad 7 released and pressed again (each debounced) → overflow pulses once and only one code 7 is delivered.
- rst_n asserted low while 3 codes are queued → code_valid=0 immediately (asynchronous); after release with no presses, code_valid stays 0. With PAD_RELEASE_EVENT_EN, a press then release of pad 2 gives code 2 with release=0, then code 2 with release=1.

Source files
------------

// File: rtl/pad_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pad_enc_pkg
//  Brief    : Shared widths, types and the lowest-set-bit helper for the
//             16-pad keypad encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package pad_enc_pkg;

  localparam int NUM_PADS = 16;
  localparam int CODE_W   = 4;

  typedef logic [CODE_W-1:0]   pad_code_t;
  typedef logic [NUM_PADS-1:0] pad_mask_t;

  // Index of the least-significant set bit; 0 when the mask is empty, so
  // callers must qualify the result with a non-zero test.
  function automatic pad_code_t lowest_set_index(input pad_mask_t m);
    pad_code_t idx;
    idx = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (m[i]) idx = pad_code_t'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pad_debounce
//  Brief    : One pad: 2-FF synchroniser, stability counter, debounced state
//             and single-cycle edge pulses of the debounced state.
//  Options  : PAD_RELEASE_EVENT_EN adds the falling-edge pulse output.
//  Revision : 1.0 - initial release
// ============================================================================
module pad_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_raw,
  output logic state,
  output logic rise
`ifdef PAD_RELEASE_EVENT_EN
  ,
  output logic fall
`endif
);

  localparam int CNT_W = 8;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             state_d;

  // Two-stage synchroniser for the asynchronous pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pad_raw};
  end

  // Count consecutive disagreeing samples; flip once DEB_CYCLES are seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sync[1] != state) begin
      if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        state <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy gives the one-cycle edge pulses that feed the pending masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_d <= 1'b0;
    else        state_d <= state;
  end

  assign rise = state & ~state_d;
`ifdef PAD_RELEASE_EVENT_EN
  assign fall = ~state & state_d;
`endif

endmodule
`default_nettype wire

// File: rtl/pad_encoder16.sv
`default_nettype none
// ============================================================================
//  Module   : pad_encoder16
//  Brief    : 16-pad keypad front end: debounce, press-event pending mask,
//             lowest-index arbiter and first-word-fall-through code FIFO
//             with a valid/ready output.
//  Options  : PAD_RELEASE_EVENT_EN queues release events too (code_release).
//  Revision : 1.0 - initial release
// ============================================================================
module pad_encoder16
  import pad_enc_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [CODE_W-1:0]   code_out,
  output logic                code_valid,
  input  logic                code_ready,
  output logic                overflow,
  output logic                pressed_any
`ifdef PAD_RELEASE_EVENT_EN
  ,
  output logic                code_release
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PAD_RELEASE_EVENT_EN
  localparam int ENTRY_W = CODE_W + 1;   // {release, code}
`else
  localparam int ENTRY_W = CODE_W;
`endif

  typedef logic [ENTRY_W-1:0] entry_t;

  pad_mask_t        deb_state;
  pad_mask_t        deb_rise;
  pad_mask_t        pending;
  pad_mask_t        grant;
  logic             drop_press;
  logic             drop_rel;

  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  entry_t           push_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push;
  logic             pop;

`ifdef PAD_RELEASE_EVENT_EN
  pad_mask_t        deb_fall;
  pad_mask_t        pending_rel;
  pad_mask_t        grant_rel;
`endif

  generate
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      pad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .pad_raw (pad_in[i]),
        .state   (deb_state[i]),
        .rise    (deb_rise[i])
`ifdef PAD_RELEASE_EVENT_EN
        ,
        .fall    (deb_fall[i])
`endif
      );
    end
  endgenerate

  assign full       = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign code_valid = (count != '0);
  assign pop        = code_valid & code_ready;

  // Arbiter: one push per cycle, presses before releases, lowest index first.
  // A simultaneous pop frees the slot, so a full FIFO still accepts a push.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    grant      = '0;
`ifdef PAD_RELEASE_EVENT_EN
    grant_rel  = '0;
`endif
    if (!full || pop) begin
      if (pending != '0) begin
        push                               = 1'b1;
        push_entry                         = entry_t'(lowest_set_index(pending));
        grant[lowest_set_index(pending)]   = 1'b1;
      end
`ifdef PAD_RELEASE_EVENT_EN
      else if (pending_rel != '0) begin
        push                                   = 1'b1;
        push_entry                             = {1'b1, lowest_set_index(pending_rel)};
        grant_rel[lowest_set_index(pending_rel)] = 1'b1;
      end
`endif
    end
  end

  // An event is lost only if its bit is still pending after this cycle's grant.
  assign drop_press = |(deb_rise & pending & ~grant);
`ifdef PAD_RELEASE_EVENT_EN
  assign drop_rel   = |(deb_fall & pending_rel & ~grant_rel);
`else
  assign drop_rel   = 1'b0;
`endif

  // Pending press mask and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~grant) | deb_rise;
      overflow <= drop_press | drop_rel;
    end
  end

`ifdef PAD_RELEASE_EVENT_EN
  // Pending release mask, same hold-until-granted behaviour as presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_rel <= '0;
    else        pending_rel <= (pending_rel & ~grant_rel) | deb_fall;
  end
`endif

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are gated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head        = mem[rd_ptr];
  assign code_out    = code_valid ? head[CODE_W-1:0] : '0;
`ifdef PAD_RELEASE_EVENT_EN
  assign code_release = code_valid ? head[CODE_W] : 1'b0;
`endif

  // Debounced states are flops, so this OR adds no delay beyond debounce.
  assign pressed_any = |deb_state;

endmodule
`default_nettype wire

// File: tb/tb_pad_encoder16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pad_encoder16
//  Brief    : Self-checking bench for pad_encoder16 (directed scenarios plus
//             randomized pad/ready activity against a behavioural model).
//  Options  : PAD_RELEASE_EVENT_EN adds the release-event scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pad_encoder16;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pad_in = '0;
  logic        code_ready = 1'b0;
  logic [3:0]  code_out;
  logic        code_valid;
  logic        overflow;
  logic        pressed_any;
`ifdef PAD_RELEASE_EVENT_EN
  logic        code_release;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pad_encoder16 #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_in      (pad_in),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .overflow    (overflow),
    .pressed_any (pressed_any)
`ifdef PAD_RELEASE_EVENT_EN
    ,
    .code_release(code_release)
`endif
  );

  // ------------------------------------------------------------------------
  // Behavioural model: per-pad sample history and stability counts, event
  // bitmaps and a queue of {release, code} entries.
  // ------------------------------------------------------------------------
  logic [15:0] m_s1, m_s2, m_deb, m_evt, m_evt_rel, m_pend, m_pend_rel;
  int          m_cnt [16];
  logic [4:0]  m_q [$];
  logic        m_ovf;

  function automatic int first_one(input logic [15:0] m);
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return 0;
  endfunction

  task automatic model_step();
    int          sz;
    bit          popped;
    int          k;
    logic [15:0] gp, gr;
    sz     = m_q.size();
    popped = (sz > 0) && code_ready;
    if (popped) void'(m_q.pop_front());
    gp = '0;
    gr = '0;
    if (sz < DEPTH || popped) begin
      if (m_pend != 0) begin
        k = first_one(m_pend);
        m_q.push_back({1'b0, 4'(k)});
        gp[k] = 1'b1;
      end else if (m_pend_rel != 0) begin
        k = first_one(m_pend_rel);
        m_q.push_back({1'b1, 4'(k)});
        gr[k] = 1'b1;
      end
    end
    m_pend     = m_pend & ~gp;
    m_pend_rel = m_pend_rel & ~gr;
    m_ovf      = |(m_evt & m_pend) | |(m_evt_rel & m_pend_rel);
    m_pend     = m_pend | m_evt;
    m_pend_rel = m_pend_rel | m_evt_rel;
    m_evt      = '0;
    m_evt_rel  = '0;
    for (int i = 0; i < 16; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_cnt[i] = 0;
          if (m_deb[i]) m_evt[i] = 1'b1;
`ifdef PAD_RELEASE_EVENT_EN
          else          m_evt_rel[i] = 1'b1;
`endif
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = pad_in;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_evt = '0; m_evt_rel = '0;
      m_pend = '0; m_pend_rel = '0; m_ovf = 1'b0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_q.delete();
    end else begin
      model_step();
    end
  end

  // ------------------------------------------------------------------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    pad_in     = '0;
    code_ready = 1'b1;
    settle(30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pad_in = '0; code_ready = 1'b0;
    settle(3);
    checks++; if (code_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", code_valid); end
    checks++; if (code_out !== 4'd0)    begin errors++; $display("FAIL reset_code got %0d want 0", code_out); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (pressed_any !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b want 0", pressed_any); end
    rst_n = 1'b1;
    settle(2);
  endtask

  task automatic test_single_press();
    int  edge_no;
    bit  found;
    drain();
    pad_in = 16'h0001;
    edge_no = 0; found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      @(negedge clk);
      if (code_valid === 1'b1) begin found = 1; edge_no = e; end
    end
    checks++; if (!found || edge_no != DEB + 4) begin errors++; $display("FAIL press_latency got %0d edges want %0d", edge_no, DEB + 4); end
    checks++; if (code_out !== 4'd0)    begin errors++; $display("FAIL press_code got %0d want 0", code_out); end
    checks++; if (pressed_any !== 1'b1) begin errors++; $display("FAIL press_any got %b want 1", pressed_any); end
    @(negedge clk);
    checks++; if (code_valid !== 1'b0)  begin errors++; $display("FAIL press_one_cycle got %b want 0", code_valid); end
    drain();
  endtask

  task automatic test_glitch();
    bit saw_valid, saw_any;
    drain();
    pad_in = 16'h0020;
    settle(3);
    pad_in = '0;
    saw_valid = 0; saw_any = 0;
    repeat (15) begin
      @(negedge clk);
      if (code_valid) saw_valid = 1;
      if (pressed_any) saw_any = 1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL glitch_valid got 1 want 0"); end
    checks++; if (saw_any)   begin errors++; $display("FAIL glitch_pressed got 1 want 0"); end
  endtask

  task automatic test_simultaneous();
    int exp_codes [4] = '{0, 5, 10, 15};
    bit found;
    drain();
    pad_in = 16'h8421;
    found = 0;
    for (int e = 0; e < 20 && !found; e++) begin
      @(negedge clk);
      if (code_valid) found = 1;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (code_valid !== 1'b1 || code_out !== 4'(exp_codes[j])) begin
        errors++; $display("FAIL simul_code%0d got v=%b c=%0d want v=1 c=%0d", j, code_valid, code_out, exp_codes[j]);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    bit saw_ovf;
    drain();
    code_ready = 1'b0;
    pad_in = 16'h003F;
    saw_ovf = 0;
    repeat (20) begin @(negedge clk); if (overflow) saw_ovf = 1; end
    checks++; if (code_valid !== 1'b1 || code_out !== 4'd0) begin errors++; $display("FAIL full_head got v=%b c=%0d want v=1 c=0", code_valid, code_out); end
    checks++; if (saw_ovf) begin errors++; $display("FAIL full_ovf got 1 want 0"); end
    code_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) ; // first negedge already shows code 1 after popping 0
    end
    drain();
  endtask

  task automatic test_fifo_order();
    drain();
    code_ready = 1'b0;
    pad_in = 16'h003F;
    settle(20);
    code_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (code_valid !== 1'b1 || code_out !== 4'(j)) begin
        errors++; $display("FAIL order_code%0d got v=%b c=%0d want v=1 c=%0d", j, code_valid, code_out, j);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_overflow();
    int ovf_cnt;
    int exp_codes [5] = '{0, 1, 2, 3, 7};
    drain();
    code_ready = 1'b0;
    pad_in = 16'h008F;
    ovf_cnt = 0;
    repeat (15) begin @(negedge clk); if (overflow) ovf_cnt++; end
    pad_in = 16'h000F;
    repeat (12) begin @(negedge clk); if (overflow) ovf_cnt++; end
    pad_in = 16'h008F;
    repeat (12) begin @(negedge clk); if (overflow) ovf_cnt++; end
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt); end
    code_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (code_valid !== 1'b1 || code_out !== 4'(exp_codes[j])) begin
        errors++; $display("FAIL ovf_code%0d got v=%b c=%0d want v=1 c=%0d", j, code_valid, code_out, exp_codes[j]);
      end
      @(negedge clk);
    end
`ifdef PAD_RELEASE_EVENT_EN
    checks++;
    if (code_valid !== 1'b1 || code_out !== 4'd7 || code_release !== 1'b1) begin
      errors++; $display("FAIL ovf_rel7 got v=%b c=%0d r=%b want v=1 c=7 r=1", code_valid, code_out, code_release);
    end
    @(negedge clk);
`endif
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL ovf_single7 got v=%b c=%0d want v=0", code_valid, code_out); end
    drain();
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    drain();
    code_ready = 1'b0;
    pad_in = 16'h0007;
    settle(15);
    checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued got %b want 1", code_valid); end
    rst_n  = 1'b0;
    pad_in = '0;
    #1;
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got %b want 0", code_valid); end
    settle(2);
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (20) begin @(negedge clk); if (code_valid) saw_valid = 1; end
    checks++; if (saw_valid) begin errors++; $display("FAIL rmid_after got 1 want 0"); end
  endtask

`ifdef PAD_RELEASE_EVENT_EN
  task automatic test_release_event();
    drain();
    code_ready = 1'b0;
    pad_in = 16'h0004;
    settle(12);
    pad_in = '0;
    settle(12);
    checks++;
    if (code_valid !== 1'b1 || code_out !== 4'd2 || code_release !== 1'b0) begin
      errors++; $display("FAIL rel_press got v=%b c=%0d r=%b want v=1 c=2 r=0", code_valid, code_out, code_release);
    end
    code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b1 || code_out !== 4'd2 || code_release !== 1'b1) begin
      errors++; $display("FAIL rel_release got v=%b c=%0d r=%b want v=1 c=2 r=1", code_valid, code_out, code_release);
    end
    @(negedge clk);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rel_empty got %b want 0", code_valid); end
    drain();
  endtask
`endif

  task automatic test_random();
    int   hold;
    logic [3:0] exp_code;
    hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_code = (m_q.size() > 0) ? m_q[0][3:0] : 4'd0;
      checks++; if (code_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, code_valid, m_q.size() > 0); end
      checks++; if (code_out !== exp_code)            begin errors++; $display("FAIL rand_code cyc %0d got %0d want %0d", cyc, code_out, exp_code); end
      checks++; if (overflow !== m_ovf)               begin errors++; $display("FAIL rand_ovf cyc %0d got %b want %b", cyc, overflow, m_ovf); end
      checks++; if (pressed_any !== (|m_deb))         begin errors++; $display("FAIL rand_any cyc %0d got %b want %b", cyc, pressed_any, |m_deb); end
`ifdef PAD_RELEASE_EVENT_EN
      checks++;
      if (code_release !== ((m_q.size() > 0) ? m_q[0][4] : 1'b0)) begin
        errors++; $display("FAIL rand_rel cyc %0d got %b", cyc, code_release);
      end
`endif
      if (hold == 0) begin
        if ($urandom_range(0, 7) == 0) pad_in = 16'($urandom);
        else pad_in = pad_in ^ (16'h0001 << $urandom_range(0, 15));
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      code_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_fifo_full();
    test_fifo_order();
    test_overflow();
    test_reset_mid();
`ifdef PAD_RELEASE_EVENT_EN
    test_release_event();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
